// File: rtl/fb_pkg.sv
// Shared constants, state encoding and helpers for the double-buffered framebuffer.
package fb_pkg;

  // Default geometry: 214 x 160 pixels, 3 bits per pixel.
  localparam int DEF_D_WIDTH   = 3;
  localparam int DEF_FB_WIDTH  = 214;
  localparam int DEF_FB_HEIGHT = 160;
  localparam int DEF_A_WIDTH   = 16;

  // Number of pixel words held by one bank.
  function automatic int total_words(input int width, input int height);
    return width * height;
  endfunction

  localparam int DEF_TOTAL_WORDS = total_words(DEF_FB_WIDTH, DEF_FB_HEIGHT);

  // Swap/clear controller states.
  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    CLEAR
  } fb_state_t;

endpackage

// File: rtl/fb_double_buffer_if.sv
// Bundle of the VGA read port, rasterizer write port and swap control/status.
// The instance parameters must match the parameters of the framebuffer it feeds.
interface fb_double_buffer_if #(
  parameter int D_WIDTH = fb_pkg::DEF_D_WIDTH,
  parameter int A_WIDTH = fb_pkg::DEF_A_WIDTH
);

  logic [A_WIDTH-1:0] vga_addr;
  logic [D_WIDTH-1:0] vga_read;
  logic               vga_frame_start;
  logic [A_WIDTH-1:0] rast_addr;
  logic               rast_write_en;
  logic [D_WIDTH-1:0] rast_write;
  logic               swap_req;
  logic               clear_on_swap;
  logic               front_sel;
  logic               busy;

  // Framebuffer side.
  modport slave (
    input  vga_addr, vga_frame_start,
    input  rast_addr, rast_write_en, rast_write,
    input  swap_req, clear_on_swap,
    output vga_read, front_sel, busy
  );

  // Rasterizer / VGA timing side.
  modport master (
    output vga_addr, vga_frame_start,
    output rast_addr, rast_write_en, rast_write,
    output swap_req, clear_on_swap,
    input  vga_read, front_sel, busy
  );

endinterface

// File: rtl/fb_bank.sv
// One framebuffer bank: single write port plus a registered read port,
// written so it maps onto block RAM.
module fb_bank #(
  parameter int D_WIDTH     = 3,
  parameter int A_WIDTH     = 16,
  parameter int TOTAL_WORDS = 34240
) (
  input  logic               clk,
  input  logic               we,
  input  logic [A_WIDTH-1:0] waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic [A_WIDTH-1:0] raddr,
  output logic [D_WIDTH-1:0] rdata
);

  logic [D_WIDTH-1:0] mem [0:TOTAL_WORDS-1];

  // Synchronous write and registered read; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fb_double_buffer.sv
// Double-buffered framebuffer. VGA reads the front bank, the rasterizer writes
// the back bank, swaps are deferred to the next frame start and may be followed
// by a hardware clear of the new back bank.
module fb_double_buffer
  import fb_pkg::*;
#(
  parameter int                 D_WIDTH     = DEF_D_WIDTH,
  parameter int                 FB_WIDTH    = DEF_FB_WIDTH,
  parameter int                 FB_HEIGHT   = DEF_FB_HEIGHT,
  parameter int                 A_WIDTH     = DEF_A_WIDTH,
  parameter logic [D_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input logic              clk,
  input logic              rst_async,
  fb_double_buffer_if.slave bus
);

  localparam int                 TOTAL_WORDS = total_words(FB_WIDTH, FB_HEIGHT);
  // One extra bit so address range checks never overflow.
  localparam logic [A_WIDTH:0]   TOTAL_EXT   = (A_WIDTH + 1)'(TOTAL_WORDS);
  localparam logic [A_WIDTH-1:0] LAST_ADDR   = A_WIDTH'(TOTAL_WORDS - 1);

  fb_state_t          state_reg;
  logic               front_sel_reg;
  logic               busy_reg;
  logic               clear_latch_reg;
  logic [A_WIDTH-1:0] clear_cnt_reg;

  logic               rast_in_range;
  logic               vga_in_range;

  logic               wr_en;
  logic [A_WIDTH-1:0] wr_addr;
  logic [D_WIDTH-1:0] wr_data;
  logic [A_WIDTH-1:0] rd_addr;
  logic [1:0]         bank_we;
  logic [D_WIDTH-1:0] bank_rdata [2];

  logic               rd_sel_reg;
  logic               rd_hit_reg;

  assign rast_in_range = {1'b0, bus.rast_addr} < TOTAL_EXT;
  assign vga_in_range  = {1'b0, bus.vga_addr} < TOTAL_EXT;

  // Swap controller: latch request, toggle front bank at frame start, then optionally clear.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_reg       <= IDLE;
      front_sel_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      clear_latch_reg <= 1'b0;
      clear_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A frame start arriving with the request only arms the swap.
          if (bus.swap_req) begin
            state_reg       <= PENDING;
            busy_reg        <= 1'b1;
            clear_latch_reg <= bus.clear_on_swap;
          end
        end
        PENDING: begin
          if (bus.vga_frame_start) begin
            front_sel_reg   <= ~front_sel_reg;
            clear_cnt_reg   <= '0;
            clear_latch_reg <= 1'b0;
            if (clear_latch_reg) begin
              state_reg <= CLEAR;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end
        end
        CLEAR: begin
          // One word per cycle; the counter wraps back to 0 on the last word.
          if (clear_cnt_reg == LAST_ADDR) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            clear_cnt_reg <= '0;
          end else begin
            clear_cnt_reg <= clear_cnt_reg + A_WIDTH'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Back-bank write source: the clear engine owns the port while clearing,
  // otherwise the rasterizer may write when idle and in range.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.rast_addr;
    wr_data = bus.rast_write;
    if (state_reg == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clear_cnt_reg;
      wr_data = CLEAR_VALUE;
    end else if (!busy_reg && bus.rast_write_en && rast_in_range) begin
      wr_en = 1'b1;
    end
  end

  // Out-of-range reads are steered to word 0 and zeroed at the output.
  assign rd_addr = vga_in_range ? bus.vga_addr : '0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      // Only the bank that is not currently in front can be written.
      assign bank_we[gi] = wr_en && (front_sel_reg != 1'(gi));

      fb_bank #(
        .D_WIDTH     (D_WIDTH),
        .A_WIDTH     (A_WIDTH),
        .TOTAL_WORDS (TOTAL_WORDS)
      ) u_bank (
        .clk   (clk),
        .we    (bank_we[gi]),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (bank_rdata[gi])
      );
    end
  endgenerate

  // Remember which bank and whether the address was valid, aligned with the RAM read.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      rd_sel_reg <= 1'b0;
      rd_hit_reg <= 1'b0;
    end else begin
      rd_sel_reg <= front_sel_reg;
      rd_hit_reg <= vga_in_range;
    end
  end

  // rd_hit_reg is cleared by reset, so vga_read reads 0 immediately on reset.
  assign bus.vga_read  = rd_hit_reg ? bank_rdata[rd_sel_reg] : '0;
  assign bus.front_sel = front_sel_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_fb_double_buffer.sv
// Self-checking bench: behavioural bank/swap model compared every cycle,
// directed scenarios with literal expectations, and a randomized phase.
module tb_fb_double_buffer;

  localparam int D     = 3;
  localparam int A     = 16;
  localparam int TOTAL = 214 * 160;
  localparam int CLR   = 0;

  logic clk = 1'b0;
  logic rst_async = 1'b0;

  fb_double_buffer_if #(.D_WIDTH(D), .A_WIDTH(A)) bus();

  fb_double_buffer dut (
    .clk       (clk),
    .rst_async (rst_async),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: two arrays of pixels, a known-mask for never-written
  // RAM, the front index, and the swap/clear bookkeeping.
  int mbank  [2][TOTAL];
  bit mknown [2][TOTAL];
  int mfront = 0;
  bit mpend = 0, mlatch = 0, mclr = 0;
  int mcidx = 0;
  int mexp = 0;
  bit mexp_known = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model update on each active edge (or reset).
  always @(posedge clk or posedge rst_async) begin : model
    int a;
    int w;
    bit was_busy;
    if (rst_async) begin
      mfront = 0; mpend = 0; mlatch = 0; mclr = 0; mcidx = 0;
      mexp = 0; mexp_known = 1;
    end else begin
      a = int'(bus.vga_addr);
      if (a >= TOTAL) begin
        mexp = 0; mexp_known = 1;
      end else begin
        mexp = mbank[mfront][a]; mexp_known = mknown[mfront][a];
      end
      was_busy = mpend || mclr;
      w = int'(bus.rast_addr);
      if (bus.rast_write_en && !was_busy && w < TOTAL) begin
        mbank[1 - mfront][w]  = int'(bus.rast_write);
        mknown[1 - mfront][w] = 1;
      end
      if (mclr) begin
        mbank[1 - mfront][mcidx]  = CLR;
        mknown[1 - mfront][mcidx] = 1;
        mcidx++;
        if (mcidx == TOTAL) mclr = 0;
      end else if (mpend) begin
        if (bus.vga_frame_start) begin
          mfront = 1 - mfront;
          mpend  = 0;
          if (mlatch) begin mclr = 1; mcidx = 0; end
        end
      end else if (bus.swap_req) begin
        mpend  = 1;
        mlatch = bus.clear_on_swap;
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    chk("busy", int'(bus.busy), int'(mpend || mclr));
    chk("front_sel", int'(bus.front_sel), mfront);
    if (mexp_known) chk("vga_read", int'(bus.vga_read), mexp);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (bus.busy && n < TOTAL + 100) begin
      n++;
      cyc();
    end
    chk(nm, int'(bus.busy), 0);
  endtask

  task automatic pulse_swap(input bit clr);
    bus.swap_req = 1; bus.clear_on_swap = clr;
    cyc();
    bus.swap_req = 0; bus.clear_on_swap = 0;
    repeat (3) cyc();
    bus.vga_frame_start = 1;
    cyc();
    bus.vga_frame_start = 0;
  endtask

  task automatic rd(input string nm, input int addr, input int exp);
    bus.vga_addr = A'(addr);
    cyc();
    chk(nm, int'(bus.vga_read), exp);
  endtask

  task automatic wr(input int addr, input int data);
    bus.rast_write_en = 1; bus.rast_addr = A'(addr); bus.rast_write = D'(data);
    cyc();
    bus.rast_write_en = 0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.vga_addr = '0; bus.vga_frame_start = 0; bus.rast_addr = '0;
    bus.rast_write_en = 0; bus.rast_write = '0; bus.swap_req = 0; bus.clear_on_swap = 0;

    // Reset state.
    rst_async = 1;
    repeat (3) cyc();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_front", int'(bus.front_sel), 0);
    chk("rst_read", int'(bus.vga_read), 0);
    rst_async = 0;
    cyc();
    $display("txn reset released");

    // Swap request together with frame start only arms the swap.
    bus.swap_req = 1; bus.clear_on_swap = 1; bus.vga_frame_start = 1;
    cyc();
    bus.swap_req = 0; bus.clear_on_swap = 0; bus.vga_frame_start = 0;
    chk("simul_front", int'(bus.front_sel), 0);
    chk("simul_busy", int'(bus.busy), 1);
    repeat (5) cyc();
    chk("pending_front", int'(bus.front_sel), 0);
    bus.vga_frame_start = 1;
    cyc();
    bus.vga_frame_start = 0;
    chk("swap1_front", int'(bus.front_sel), 1);
    n = 0;
    while (bus.busy && n < TOTAL + 20) begin
      n++;
      cyc();
    end
    chk("clear_len", n, 34240);
    $display("txn swap+clear 1 done, busy cycles=%0d", n);

    // Second clearing swap, with writes to addr 20 attempted while busy.
    bus.swap_req = 1; bus.clear_on_swap = 1;
    cyc();
    bus.swap_req = 0; bus.clear_on_swap = 0;
    bus.rast_write_en = 1; bus.rast_addr = 16'd20; bus.rast_write = 3'd7;
    repeat (3) cyc();
    bus.vga_frame_start = 1;
    cyc();
    bus.vga_frame_start = 0;
    repeat (100) cyc();
    bus.rast_write_en = 0;
    wait_idle("clear2_idle");
    chk("swap2_front", int'(bus.front_sel), 0);
    $display("txn swap+clear 2 done, front=%0d", bus.front_sel);

    // Cleared front bank reads CLEAR_VALUE; out-of-range reads give 0.
    rd("clr_addr0", 0, CLR);
    rd("clr_last", TOTAL - 1, CLR);
    rd("clr_addr20", 20, CLR);
    for (int i = 0; i < 200; i++) rd("clr_rand", $urandom_range(0, TOTAL - 1), CLR);
    rd("oor_34240", 34240, 0);
    rd("oor_max", 65535, 0);
    $display("txn cleared-bank sweep done");

    // Back-bank write is invisible until the swap; out-of-range write dropped.
    wr(10, 5);
    wr(40000, 7);
    rd("front_addr10", 10, 0);
    $display("txn wrote 5 to back addr 10");

    // Plain swap: the toggle-cycle read returns old front, the next one the new.
    bus.swap_req = 1; bus.clear_on_swap = 0;
    cyc();
    bus.swap_req = 0;
    chk("swap3_busy", int'(bus.busy), 1);
    repeat (2) cyc();
    chk("swap3_busy_hold", int'(bus.busy), 1);
    bus.vga_frame_start = 1; bus.vga_addr = 16'd10;
    cyc();
    bus.vga_frame_start = 0;
    chk("swap3_front", int'(bus.front_sel), 1);
    chk("swap3_busy_clr", int'(bus.busy), 0);
    chk("toggle_read_old", int'(bus.vga_read), 0);
    cyc();
    chk("swap_read10", int'(bus.vga_read), 5);
    rd("busy_write_dropped20", 20, 0);
    rd("oor_write_dropped", 40000 - 32768, 0);
    $display("txn plain swap done, front=%0d", bus.front_sel);

    // Randomized traffic with occasional non-clearing swaps.
    for (int i = 0; i < 4000; i++) begin
      bus.vga_addr = ($urandom_range(0, 15) == 0) ? A'(TOTAL + $urandom_range(0, 30000))
                   : ($urandom_range(0, 1) == 1) ? A'($urandom_range(0, 63))
                   : A'($urandom_range(0, TOTAL - 1));
      bus.rast_write_en = ($urandom_range(0, 1) == 1);
      bus.rast_addr = ($urandom_range(0, 15) == 0) ? A'(TOTAL + $urandom_range(0, 30000))
                    : A'($urandom_range(0, 63));
      bus.rast_write = D'($urandom_range(0, 7));
      bus.swap_req = ($urandom_range(0, 49) == 0);
      bus.clear_on_swap = 0;
      bus.vga_frame_start = ($urandom_range(0, 29) == 0);
      cyc();
    end
    bus.rast_write_en = 0; bus.swap_req = 0; bus.vga_frame_start = 0;
    wait_idle("random_idle");
    $display("txn random phase done, front=%0d", bus.front_sel);

    // Reset in the middle of a clear, then a fresh swap.
    if (bus.front_sel) pulse_swap(0);
    wait_idle("pre_abort_idle");
    pulse_swap(1);
    repeat (500) cyc();
    chk("abort_busy_before", int'(bus.busy), 1);
    #2 rst_async = 1;
    #1;
    chk("abort_rst_busy", int'(bus.busy), 0);
    chk("abort_rst_front", int'(bus.front_sel), 0);
    chk("abort_rst_read", int'(bus.vga_read), 0);
    cyc();
    rst_async = 0;
    cyc();
    $display("txn reset during clear");
    pulse_swap(0);
    chk("post_abort_front", int'(bus.front_sel), 1);
    chk("post_abort_busy", int'(bus.busy), 0);
    for (int i = 0; i < 300; i++) begin
      bus.vga_addr = A'($urandom_range(0, 1023));
      cyc();
    end
    $display("txn post-reset swap done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
